// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Sizes, FSM state codes and the latched request record live here.
package dmem_access_ctrl_pkg;
    localparam int ADDR_SIZE = 32;
    localparam int WORD_SIZE = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        DAC_IDLE = 2'b00,
        DAC_RD   = 2'b01,
        DAC_WR   = 2'b10,
        DAC_RESP = 2'b11
    } dac_state_t;

    typedef struct packed {
        logic                 we;
        logic [1:0]           size;
        logic                 sgn;
        logic [1:0]           off;
        logic [WORD_SIZE-1:0] wdata;
    } dac_req_t;

    // Size code 2'b11 behaves exactly like a word access.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction
endpackage

// File: rtl/dmem_access_ctrl_lane_merge.sv
// dmem_lane_merge: combinational lane extract (loads) and lane merge (sub-word stores).
// BIG_ENDIAN=1 places byte offset 0 in bits [31:24].
module dmem_lane_merge
    import dmem_access_ctrl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [WORD_SIZE-1:0] word,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic [1:0]           off,
    input  logic [1:0]           size,
    input  logic                 sgn,
    output logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] merged
);
    logic [4:0]           shamt;
    logic [WORD_SIZE-1:0] mask;
    logic [WORD_SIZE-1:0] ext;

    // Big-endian lane k sits 8*(3-k) bits up, which is 8*~k for a 2-bit k.
    always_comb begin
        shamt = 5'd0;
        mask  = '1;
        if (is_word(size)) begin
            shamt = 5'd0;
            mask  = '1;
        end else if (size == SZ_HALF) begin
            shamt = BIG_ENDIAN ? {~off[1], 4'b0000} : {off[1], 4'b0000};
            mask  = WORD_SIZE'(16'hFFFF) << shamt;
        end else begin
            shamt = BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
            mask  = WORD_SIZE'(8'hFF) << shamt;
        end
    end

    assign ext = word >> shamt;

    always_comb begin
        rdata = ext;
        if (!is_word(size)) begin
            if (size == SZ_HALF) rdata = {{16{sgn & ext[15]}}, ext[15:0]};
            else                 rdata = {{24{sgn & ext[7]}},  ext[7:0]};
        end
    end

    assign merged = (word & ~mask) | ((wdata << shamt) & mask);
endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage master for DMem: word-aligned cycles, load extraction, RMW for sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests respond with resp_err and no DMem cycle.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_signed,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_read,
    output logic                 mem_write,
    input  logic [WORD_SIZE-1:0] mem_rdata
);
    dac_state_t           state_q, state_d;
    dac_req_t             req_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic                 err_q, err_d;
    logic [ADDR_SIZE-1:0] mem_addr_d;
    logic [WORD_SIZE-1:0] mem_wdata_d;
    logic                 mem_read_d, mem_write_d;
    logic                 accept, trap_hit;
    logic [WORD_SIZE-1:0] lane_word, lane_rdata, lane_merged;

    assign req_ready  = (state_q == DAC_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == DAC_RESP);

`ifdef MISALIGN_TRAP_EN
    assign trap_hit = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
    assign resp_err = resp_valid && err_q;
`else
    assign trap_hit = 1'b0;
    assign resp_err = 1'b0;
`endif

    // Merge works on the word arriving this cycle; extract works on the captured copy.
    assign lane_word  = (state_q == DAC_RD) ? mem_rdata : rdata_q;
    assign resp_rdata = (resp_valid && !req_q.we && !err_q) ? lane_rdata : '0;

    dmem_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .word   (lane_word),
        .wdata  (req_q.wdata),
        .off    (req_q.off),
        .size   (req_q.size),
        .sgn    (req_q.sgn),
        .rdata  (lane_rdata),
        .merged (lane_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DAC_IDLE;
            req_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            if (accept)
                req_q <= '{we: req_we, size: req_size, sgn: req_signed,
                           off: req_addr[1:0], wdata: req_wdata};
            if (state_q == DAC_RD)
                rdata_q <= mem_rdata;
        end
    end

    // Strobes default low so each one lasts exactly the single cycle it is requested.
    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            DAC_IDLE: begin
                if (accept) begin
                    mem_addr_d = {req_addr[ADDR_SIZE-1:2], 2'b00};
                    err_d      = trap_hit;
                    if (trap_hit) begin
                        state_d = DAC_RESP;
                    end else if (req_we && is_word(req_size)) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = req_wdata;
                        state_d     = DAC_WR;
                    end else begin
                        mem_read_d = 1'b1;
                        state_d    = DAC_RD;
                    end
                end
            end
            DAC_RD: begin
                if (req_q.we) begin
                    mem_write_d = 1'b1;
                    mem_wdata_d = lane_merged;
                    state_d     = DAC_WR;
                end else begin
                    state_d = DAC_RESP;
                end
            end
            DAC_WR:   state_d = DAC_RESP;
            DAC_RESP: state_d = DAC_IDLE;
            default:  state_d = DAC_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench: controller paired with a negedge-sampling DMem model and a byte-level reference.
module tb_dmem_access_ctrl;
    localparam bit BE = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [31:0] dout = '0;

    logic [31:0] dmem [16];
    logic [31:0] refm [16];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.BIG_ENDIAN(BE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(dout)
    );

    // DMem: samples strobes on the falling edge
    always @(negedge clk) begin
        if (poke_en) dmem[poke_idx] <= poke_val;
        else if (mem_write) dmem[mem_addr[5:2]] <= mem_wdata;
        if (mem_read) dout <= dmem[mem_addr[5:2]];
    end

    task automatic poke(input int idx, input logic [31:0] val);
        poke_en = 1'b1; poke_idx = 4'(idx); poke_val = val;
        @(negedge clk); #1;
        poke_en = 1'b0;
        refm[idx] = val;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] a);
        logic [7:0]  b [4];
        logic [15:0] h;
        int o;
        for (int i = 0; i < 4; i++) b[i] = BE ? w[31-8*i -: 8] : w[8*i +: 8];
        if (sz[1]) return w;
        if (sz == 2'b01) begin
            o = a[1] ? 2 : 0;
            h = BE ? {b[o], b[o+1]} : {b[o+1], b[o]};
            return sg ? {{16{h[15]}}, h} : {16'h0, h};
        end
        return sg ? {{24{b[a][7]}}, b[a]} : {24'h0, b[a]};
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] a, input logic [31:0] wd);
        logic [7:0]  b [4];
        logic [31:0] r;
        int o;
        if (sz[1]) return wd;
        for (int i = 0; i < 4; i++) b[i] = BE ? w[31-8*i -: 8] : w[8*i +: 8];
        if (sz == 2'b01) begin
            o = a[1] ? 2 : 0;
            b[o]   = BE ? wd[15:8] : wd[7:0];
            b[o+1] = BE ? wd[7:0]  : wd[15:8];
        end else begin
            b[a] = wd[7:0];
        end
        r = '0;
        for (int i = 0; i < 4; i++)
            if (BE) r[31-8*i -: 8] = b[i]; else r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Issue one request and observe it #1 after every edge until resp_valid (bounded).
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nrd, output int nwr, output bit got, output bit bad);
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        bad = !req_ready;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; got = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            lat++;
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (req_ready || (mem_read && mem_write)) bad = 1'b1;
            if (resp_valid) begin
                rd = resp_rdata; er = resp_err; got = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #2;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
        end
        checks++;
        if ({mem_addr, mem_wdata, resp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, resp_rdata);
        end
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [31:0] rd; logic er; int lat, nrd, nwr; bit got, bad;
        poke(1, 32'h11223344);
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || bad || rd !== 32'h11223344 || lat != 2 || nrd != 1 || nwr != 0) begin
            errors++;
            $display("FAIL lw4 got rd=%h lat=%0d rd#=%0d wr#=%0d ok=%0d bad=%0d want 11223344 2 1 0", rd, lat, nrd, nwr, got, bad);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || rd !== 32'h00000044 || lat != 2) begin
            errors++;
            $display("FAIL lbu7 got %h lat=%0d want 00000044 2", rd, lat);
        end
        poke(1, 32'h112233F4);
        issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || rd !== 32'hFFFFFFF4) begin
            errors++;
            $display("FAIL lb7 got %h want fffffff4", rd);
        end
        poke(1, 32'h11223344);
        issue(1'b1, 2'b01, 1'b0, 32'h4, 32'h0000ABCD, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || bad || dmem[1] !== 32'hABCD3344 || lat != 3 || nrd != 1 || nwr != 1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sh4 got mem=%h lat=%0d rd#=%0d wr#=%0d rdata=%h want abcd3344 3 1 1 0", dmem[1], lat, nrd, nwr, rd);
        end
        refm[1] = 32'hABCD3344;
        issue(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || dmem[2] !== 32'hDEADBEEF || lat != 2 || nrd != 0 || nwr != 1) begin
            errors++;
            $display("FAIL sw8 got mem=%h lat=%0d rd#=%0d wr#=%0d want deadbeef 2 0 1", dmem[2], lat, nrd, nwr);
        end
        refm[2] = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat, nrd, nwr, got, bad);
        checks++;
        if (!got || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw8 got %h want deadbeef", rd);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0, rd, er, lat, nrd, nwr, got, bad);
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (!got || er !== 1'b1 || rd !== 32'h0 || lat != 1 || nrd != 0 || nwr != 0) begin
            errors++;
            $display("FAIL lw6_trap got err=%b rd=%h lat=%0d rd#=%0d wr#=%0d want 1 0 1 0 0", er, rd, lat, nrd, nwr);
        end
`else
        if (!got || er !== 1'b0 || rd !== 32'hABCD3344 || lat != 2) begin
            errors++;
            $display("FAIL lw6 got err=%b rd=%h lat=%0d want 0 abcd3344 2", er, rd, lat);
        end
`endif
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, exp_rd; logic er, we, sg, mis; logic [1:0] sz;
        int lat, nrd, nwr, exp_lat, exp_rd_n, exp_wr_n, idx; bit got, bad;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 63)); wd = $urandom; idx = int'(a[5:2]);
`ifdef MISALIGN_TRAP_EN
            mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
            mis = 1'b0;
`endif
            exp_rd = '0;
            if (mis) begin
                exp_lat = 1; exp_rd_n = 0; exp_wr_n = 0;
            end else if (!we) begin
                exp_lat = 2; exp_rd_n = 1; exp_wr_n = 0;
                exp_rd = ref_load(refm[idx], sz, sg, a[1:0]);
            end else if (sz[1]) begin
                exp_lat = 2; exp_rd_n = 0; exp_wr_n = 1;
                refm[idx] = wd;
            end else begin
                exp_lat = 3; exp_rd_n = 1; exp_wr_n = 1;
                refm[idx] = ref_store(refm[idx], sz, a[1:0], wd);
            end
            issue(we, sz, sg, a, wd, rd, er, lat, nrd, nwr, got, bad);
            checks++;
            if (!got || bad || rd !== exp_rd || er !== mis || lat != exp_lat ||
                nrd != exp_rd_n || nwr != exp_wr_n) begin
                errors++;
                $display("FAIL rand%0d we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d %0d/%0d want %h %b %0d %0d/%0d ok=%0d bad=%0d",
                         n, we, sz, a, rd, er, lat, nrd, nwr, exp_rd, mis, exp_lat, exp_rd_n, exp_wr_n, got, bad);
            end
            checks++;
            if (dmem[idx] !== refm[idx]) begin
                errors++;
                $display("FAIL rand%0d_mem[%0d] got %h want %h", n, idx, dmem[idx], refm[idx]);
            end
        end
    endtask

    task automatic test_abort;
        poke(1, 32'h11223344);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h4; req_wdata = 32'hABCD;
        req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL abort_wr_cycle got %b want 1", mem_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000 ||
            {mem_addr, mem_wdata, resp_rdata} !== 96'h0) begin
            errors++;
            $display("FAIL abort_outputs got %b %h %h %h want 10000 0 0 0",
                     {req_ready, resp_valid, resp_err, mem_read, mem_write}, mem_addr, mem_wdata, resp_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (dmem[1] !== 32'h11223344) begin
            errors++;
            $display("FAIL abort_mem got %h want 11223344", dmem[1]);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_abort;
        test_directed;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
